ula_operand_stage: RTL
======================

Name: ula_operand_stage

Overview:
- Execute-stage input register that sits directly upstream of the ALU.
- Captures decoded operations and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and presents registered X, Y and sel to the ALU.
- Uses a valid/ready handshake on both sides, supports pipeline flush and keeps a saturating hazard-stall counter.

Parameters:
- XLEN, 32, operand and result width.
- REGW, 5, register address width.
- SELW, 4, ALU operation select width.
- MAX_SEL, 4'b1010, highest legal ALU select code.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a decoded op.
- in_ready  out  1  stage accepts the op this cycle.
- in_sel  in  SELW  ALU operation.
- in_rs1  in  REGW  source register for X.
- in_rs2  in  REGW  source register for Y.
- in_rv1  in  XLEN  register-file value for rs1.
- in_rv2  in  XLEN  register-file value for rs2.
- in_imm  in  XLEN  immediate.
- in_use_imm  in  1  Y takes in_imm instead of rs2.
- fwd_a_en  in  1  EX/MEM stage will write fwd_a_rd.
- fwd_a_rd  in  REGW  EX/MEM destination register.
- fwd_a_data  in  XLEN  EX/MEM result.
- fwd_a_pending  in  1  EX/MEM op is a load; its data is not yet valid.
- fwd_b_en  in  1  MEM/WB stage will write fwd_b_rd.
- fwd_b_rd  in  REGW  MEM/WB destination register.
- fwd_b_data  in  XLEN  MEM/WB result.
- flush  in  1  discard held and incoming op.
- out_valid  out  1  X/Y/sel valid for the ALU.
- out_ready  in  1  downstream consumes the op.
- out_sel  out  SELW  registered select.
- out_x  out  XLEN  registered X operand.
- out_y  out  XLEN  registered Y operand.
- out_illegal  out  1  held sel is greater than MAX_SEL.
- stall_cnt  out  CNTW  number of load-use stall cycles.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_sel=0, out_x=0, out_y=0, out_illegal=0, stall_cnt=0. rst overrides flush and capture.
- Source usage:
  - rs1 is always used.
  - rs2 is used only when in_use_imm=0 and in_sel is not 4'b0111 (NOT).
  - An unused source never forwards and never causes a hazard.
- Forwarding per used source, evaluated combinationally on the input side:
  - Register 0 never matches; its value is taken from in_rv as-is.
  - Priority: fwd_a (when en, rd matches and not pending) first, then fwd_b (when en and rd matches), then in_rv.
  - Y = in_imm when in_use_imm=1.
- Hazard: hazard = in_valid and fwd_a_en and fwd_a_pending and fwd_a_rd≠0 and fwd_a_rd matches a used source.
  - A pending fwd_a match never falls through to fwd_b or in_rv.
- Handshake:
  - in_ready = (!out_valid or out_ready) and !hazard. This is combinational.
  - Capture occurs when in_valid and in_ready: register forwarded X, Y, in_sel, and out_illegal=(in_sel>MAX_SEL). Set out_valid=1.
  - Consumption without capture (out_valid and out_ready, no capture): out_valid=0; data registers hold their values.
  - Held op (out_valid=1, out_ready=0): out_sel, out_x and out_y are stable. No re-forwarding is performed.
  - Back-to-back: consume and capture in the same cycle gives one op per cycle, with zero bubble.
- Latency: one cycle from capture to out_valid.
- Flush: at the next edge out_valid=0. Any simultaneous capture is discarded. Data registers may retain their values. stall_cnt is unaffected. in_ready follows the normal equation during flush.
- stall_cnt: increments by 1 on every cycle where hazard=1 and flush=0, and saturates at all-ones.
- Illegal select: the op passes through with out_illegal=1; X and Y are computed normally. The ALU yields 0 for such codes.

Test Plan:
- Reset then idle → out_valid=0, out_x=0, stall_cnt=0. Capture sel=0000, rs1=3 rv1=5, rs2=4 rv2=7 → next cycle out_valid=1, out_x=5, out_y=7, out_sel=0000.
- Same op with fwd_a_en=1 rd=3 data=100 and fwd_b_en=1 rd=3 data=200, plus fwd_b rd=4 data=9 → out_x=100, out_y=9. With fwd_a_rd=0 and rs1=0, rv1=0 → out_x=0.
- Load-use: fwd_a_pending=1 rd=3, rs1=3 for 2 cycles, then pending drops with data=0x55 → in_ready=0 for 2 cycles, stall_cnt=2, then out_x=0x55. With in_use_imm=1 and rs2=3 pending → no stall.
- Backpressure: hold out_ready=0 for 3 cycles with a new in_valid waiting → in_ready=0 and outputs stable. Raise out_ready → consume and capture in one cycle, out_valid stays 1.
- Flush asserted with in_valid=1 and a held op → next cycle out_valid=0, nothing captured. rst asserted mid-hold → all outputs 0.
- sel=4'b1100 → out_illegal=1. sel=4'b0111 with rs2 pending hazard → no stall, out_y=rv2.

Source files
------------

// File: rtl/ula_operand_stage.sv
// Execute-stage operand register feeding the ALU: resolves EX/MEM and MEM/WB
// forwarding, blocks on load-use hazards, and holds X/Y/sel behind a valid/ready handshake.
module ula_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned SELW = 4,
  parameter logic [SELW-1:0] MAX_SEL = 4'b1010,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SELW-1:0] in_sel,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rv1,
  input  logic [XLEN-1:0] in_rv2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic            fwd_a_en,
  input  logic [REGW-1:0] fwd_a_rd,
  input  logic [XLEN-1:0] fwd_a_data,
  input  logic            fwd_a_pending,
  input  logic            fwd_b_en,
  input  logic [REGW-1:0] fwd_b_rd,
  input  logic [XLEN-1:0] fwd_b_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel,
  output logic [XLEN-1:0] out_x,
  output logic [XLEN-1:0] out_y,
  output logic            out_illegal,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [SELW-1:0] SEL_NOT = SELW'(4'b0111);

  logic            rs2_used;
  logic            a_match_x;
  logic            a_match_y;
  logic            b_match_x;
  logic            b_match_y;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] x_next;
  logic [XLEN-1:0] y_next;

  // A pending fwd_a match wins the priority but stalls, so its data is never captured.
  always_comb begin
    rs2_used  = !in_use_imm && (in_sel != SEL_NOT);
    a_match_x = fwd_a_en && (fwd_a_rd != '0) && (fwd_a_rd == in_rs1);
    a_match_y = rs2_used && fwd_a_en && (fwd_a_rd != '0) && (fwd_a_rd == in_rs2);
    b_match_x = fwd_b_en && (fwd_b_rd != '0) && (fwd_b_rd == in_rs1);
    b_match_y = rs2_used && fwd_b_en && (fwd_b_rd != '0) && (fwd_b_rd == in_rs2);

    hazard = in_valid && fwd_a_pending && (a_match_x || a_match_y);

    x_next = in_rv1;
    if (a_match_x)      x_next = fwd_a_data;
    else if (b_match_x) x_next = fwd_b_data;

    y_next = in_rv2;
    if (in_use_imm)     y_next = in_imm;
    else if (a_match_y) y_next = fwd_a_data;
    else if (b_match_y) y_next = fwd_b_data;

    in_ready = (!out_valid || out_ready) && !hazard;
    capture  = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sel     <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_illegal <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid   <= 1'b1;
        out_sel     <= in_sel;
        out_x       <= x_next;
        out_y       <= y_next;
        out_illegal <= (in_sel > MAX_SEL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (hazard && !flush && (stall_cnt != {CNTW{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
